// File: rtl/m68k_regfile_gen_if.sv
// Bus bundle between the microcode decode (master) and the m68k register file (slave).
// `super` is a reserved word, so the supervisor-mode select is carried as super_mode.
interface m68k_regfile_gen_if #(
    parameter int DW   = 32,
    parameter int SELW = 4
);
    logic            ce;
    logic            super_mode;
    logic            wa_en;
    logic [SELW-1:0] wa_sel;
    logic [1:0]      wa_size;
    logic [DW-1:0]   wa_data;
    logic            wb_en;
    logic [SELW-1:0] wb_sel;
    logic [1:0]      wb_size;
    logic [DW-1:0]   wb_data;
    logic [SELW-1:0] ra_sel;
    logic [SELW-1:0] rb_sel;
    logic [DW-1:0]   ra_data;
    logic [DW-1:0]   rb_data;
    logic            collision;
    logic            size_err;

    modport master (
        output ce, super_mode,
        output wa_en, wa_sel, wa_size, wa_data,
        output wb_en, wb_sel, wb_size, wb_data,
        output ra_sel, rb_sel,
        input  ra_data, rb_data, collision, size_err
    );

    modport slave (
        input  ce, super_mode,
        input  wa_en, wa_sel, wa_size, wa_data,
        input  wb_en, wb_sel, wb_size, wb_data,
        input  ra_sel, rb_sel,
        output ra_data, rb_data, collision, size_err
    );
endinterface

// File: rtl/m68k_regfile_gen.sv
// Parametrised 68k D/A register file: two write ports, two registered read ports, USP/SSP banking.
// Define M68K_REGFILE_BYPASS_EN to make same-cycle reads return the post-write value.
module m68k_regfile_gen #(
    parameter int NDATA = 8,
    parameter int NADDR = 8,
    parameter int DW    = 32,
    parameter int SELW  = 4
) (
    input  logic              MCLK,
    input  logic              reset,
    m68k_regfile_gen_if.slave bus
);
    localparam int NREG  = NDATA + NADDR;
    localparam int NPHYS = NREG + 1;
    localparam int PW    = $clog2(NPHYS);

    localparam logic [SELW:0] NREG_W  = (SELW+1)'(NREG);
    localparam logic [SELW:0] NDATA_W = (SELW+1)'(NDATA);
    localparam logic [SELW:0] SP_W    = (SELW+1)'(NREG - 1);
    localparam logic [PW-1:0] SSP_IDX = PW'(NREG);

    logic [DW-1:0] regs_q [NPHYS];
    logic [DW-1:0] regs_d [NPHYS];
    logic [DW-1:0] ra_q, ra_d, rb_q, rb_d;
    logic          coll_q, coll_d, err_q, err_d;

    function automatic logic sel_valid(input logic [SELW-1:0] sel);
        return {1'b0, sel} < NREG_W;
    endfunction

    function automatic logic sel_is_a(input logic [SELW-1:0] sel);
        return {1'b0, sel} >= NDATA_W;
    endfunction

    // The top address register maps to slot NREG (SSP) in supervisor mode.
    function automatic logic [PW-1:0] phys(input logic [SELW-1:0] sel, input logic sup);
        if (sup && ({1'b0, sel} == SP_W))
            return SSP_IDX;
        return PW'(sel);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                            input logic [1:0] size, input logic is_a);
        logic [DW-1:0] r;
        r = old;
        if (size[1])
            r = data;
        else if (is_a)
            r = DW'($signed(data[15:0]));
        else if (size[0])
            r[15:0] = data[15:0];
        else
            r[7:0] = data[7:0];
        return r;
    endfunction

    logic          wa_valid, wb_valid, ra_valid, rb_valid;
    logic          wa_isa, wb_isa, wa_ok, wb_ok, wa_bad, wb_bad;
    logic [PW-1:0] pa, pb, pra, prb;

    assign wa_valid = sel_valid(bus.wa_sel);
    assign wb_valid = sel_valid(bus.wb_sel);
    assign ra_valid = sel_valid(bus.ra_sel);
    assign rb_valid = sel_valid(bus.rb_sel);
    assign wa_isa   = sel_is_a(bus.wa_sel);
    assign wb_isa   = sel_is_a(bus.wb_sel);
    assign pa       = phys(bus.wa_sel, bus.super_mode);
    assign pb       = phys(bus.wb_sel, bus.super_mode);
    assign pra      = phys(bus.ra_sel, bus.super_mode);
    assign prb      = phys(bus.rb_sel, bus.super_mode);

    assign wa_bad = bus.wa_en && (!wa_valid || (wa_isa && bus.wa_size == 2'b00));
    assign wb_bad = bus.wb_en && (!wb_valid || (wb_isa && bus.wb_size == 2'b00));
    assign wa_ok  = bus.wa_en && !wa_bad;
    assign wb_ok  = bus.wb_en && !wb_bad;

    // Port A wins a collision; port B is then dropped entirely.
    assign coll_d = bus.wa_en && bus.wb_en && wa_valid && wb_valid && (pa == pb);
    assign err_d  = wa_bad || wb_bad || !ra_valid || !rb_valid;

    always_comb begin
        regs_d = regs_q;
        if (wb_ok && !coll_d)
            regs_d[pb] = merge(regs_q[pb], bus.wb_data, bus.wb_size, wb_isa);
        if (wa_ok)
            regs_d[pa] = merge(regs_q[pa], bus.wa_data, bus.wa_size, wa_isa);
    end

    always_comb begin
        ra_d = '0;
        rb_d = '0;
`ifdef M68K_REGFILE_BYPASS_EN
        if (ra_valid) ra_d = regs_d[pra];
        if (rb_valid) rb_d = regs_d[prb];
`else
        if (ra_valid) ra_d = regs_q[pra];
        if (rb_valid) rb_d = regs_q[prb];
`endif
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            for (int i = 0; i < NPHYS; i++)
                regs_q[i] <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            coll_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (bus.ce) begin
            regs_q <= regs_d;
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            coll_q <= coll_d;
            err_q  <= err_d;
        end else begin
            coll_q <= 1'b0;
            err_q  <= 1'b0;
        end
    end

    assign bus.ra_data   = ra_q;
    assign bus.rb_data   = rb_q;
    assign bus.collision = coll_q;
    assign bus.size_err  = err_q;
endmodule

// File: tb/tb_m68k_regfile_gen.sv
// Scoreboard bench for m68k_regfile_gen (NADDR=7 so select 15 is out of range, SP select is 14).
// Expectations follow M68K_REGFILE_BYPASS_EN when it is defined for the build.
module tb_m68k_regfile_gen;
    localparam int DW = 32;
    localparam int SELW = 4;
`ifdef M68K_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        rst, ce, sup;
        logic        wae; logic [3:0] was; logic [1:0] wasz; logic [31:0] wad;
        logic        wbe; logic [3:0] wbs; logic [1:0] wbsz; logic [31:0] wbd;
        logic [3:0]  ras, rbs;
        logic [31:0] era, erb;
        logic        ecoll, eerr;
    } step_t;

    typedef struct {
        string       tag;
        logic [31:0] ra, rb;
        logic        coll, err;
    } exp_t;

    logic MCLK;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    m68k_regfile_gen_if #(.DW(DW), .SELW(SELW)) bus();

    m68k_regfile_gen #(.NDATA(8), .NADDR(7), .DW(DW), .SELW(SELW)) dut (
        .MCLK  (MCLK),
        .reset (reset),
        .bus   (bus)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input step_t st, input string tag);
        exp_t e;
        reset          = st.rst;
        bus.ce         = st.ce;
        bus.super_mode = st.sup;
        bus.wa_en      = st.wae;
        bus.wa_sel     = st.was;
        bus.wa_size    = st.wasz;
        bus.wa_data    = st.wad;
        bus.wb_en      = st.wbe;
        bus.wb_sel     = st.wbs;
        bus.wb_size    = st.wbsz;
        bus.wb_data    = st.wbd;
        bus.ra_sel     = st.ras;
        bus.rb_sel     = st.rbs;
        e.tag  = tag;
        e.ra   = st.era;
        e.rb   = st.erb;
        e.coll = st.ecoll;
        e.err  = st.eerr;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        step_t s[2];
        exp_t  e;
        s[0] = '{1,0,0, 1,0,2,'hFFFFFFFF, 1,1,2,'hFFFFFFFF, 0,1, 0,0,0,0};
        s[1] = '{0,1,0, 0,0,0,0,          0,0,0,0,          0,1, 0,0,0,0};
        for (int i = 0; i < 2; i++) begin
            applyStimulus(s[i], $sformatf("reset%0d", i));
            @(posedge MCLK); #1;
            e = sb.pop_front();
            checks++; if (bus.ra_data !== e.ra) begin errors++; $display("[TB] FAIL %s ra_data got %h want %h", e.tag, bus.ra_data, e.ra); end
            checks++; if (bus.rb_data !== e.rb) begin errors++; $display("[TB] FAIL %s rb_data got %h want %h", e.tag, bus.rb_data, e.rb); end
            checks++; if (bus.collision !== e.coll) begin errors++; $display("[TB] FAIL %s collision got %b want %b", e.tag, bus.collision, e.coll); end
            checks++; if (bus.size_err !== e.err) begin errors++; $display("[TB] FAIL %s size_err got %b want %b", e.tag, bus.size_err, e.err); end
        end
    endtask

    task automatic test_dsize();
        step_t s[5];
        exp_t  e;
        s[0] = '{0,1,0, 1,3,2,'h12345678, 0,0,0,0,          0,0, 0,0,0,0};
        s[1] = '{0,1,0, 1,3,0,'hFFFFFFAB, 0,0,0,0,          0,0, 0,0,0,0};
        s[2] = '{0,1,0, 0,0,0,0,          0,0,0,0,          3,3, 'h123456AB,'h123456AB,0,0};
        s[3] = '{0,1,0, 0,0,0,0,          1,3,1,'hFFFFCDEF, 0,0, 0,0,0,0};
        s[4] = '{0,1,0, 0,0,0,0,          0,0,0,0,          3,0, 'h1234CDEF,0,0,0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(s[i], $sformatf("dsize%0d", i));
            @(posedge MCLK); #1;
            e = sb.pop_front();
            checks++; if (bus.ra_data !== e.ra) begin errors++; $display("[TB] FAIL %s ra_data got %h want %h", e.tag, bus.ra_data, e.ra); end
            checks++; if (bus.rb_data !== e.rb) begin errors++; $display("[TB] FAIL %s rb_data got %h want %h", e.tag, bus.rb_data, e.rb); end
            checks++; if (bus.collision !== e.coll) begin errors++; $display("[TB] FAIL %s collision got %b want %b", e.tag, bus.collision, e.coll); end
            checks++; if (bus.size_err !== e.err) begin errors++; $display("[TB] FAIL %s size_err got %b want %b", e.tag, bus.size_err, e.err); end
        end
    endtask

    task automatic test_areg();
        step_t s[7];
        exp_t  e;
        s[0] = '{0,1,0, 1,10,1,'h00008001, 0,0,0,0, 0,0,   0,0,0,0};
        s[1] = '{0,1,0, 0,0,0,0,           0,0,0,0, 10,10, 'hFFFF8001,'hFFFF8001,0,0};
        s[2] = '{0,1,0, 1,10,0,'h000000AA, 0,0,0,0, 10,0,  'hFFFF8001,0,0,1};
        s[3] = '{0,1,0, 1,11,1,'h00007FFF, 0,0,0,0, 10,0,  'hFFFF8001,0,0,0};
        s[4] = '{0,1,0, 0,0,0,0,           0,0,0,0, 11,10, 'h00007FFF,'hFFFF8001,0,0};
        s[5] = '{0,1,0, 1,15,2,'hDEADBEEF, 0,0,0,0, 0,0,   0,0,0,1};
        s[6] = '{0,1,0, 0,0,0,0,           0,0,0,0, 15,0,  0,0,0,1};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(s[i], $sformatf("areg%0d", i));
            @(posedge MCLK); #1;
            e = sb.pop_front();
            checks++; if (bus.ra_data !== e.ra) begin errors++; $display("[TB] FAIL %s ra_data got %h want %h", e.tag, bus.ra_data, e.ra); end
            checks++; if (bus.rb_data !== e.rb) begin errors++; $display("[TB] FAIL %s rb_data got %h want %h", e.tag, bus.rb_data, e.rb); end
            checks++; if (bus.collision !== e.coll) begin errors++; $display("[TB] FAIL %s collision got %b want %b", e.tag, bus.collision, e.coll); end
            checks++; if (bus.size_err !== e.err) begin errors++; $display("[TB] FAIL %s size_err got %b want %b", e.tag, bus.size_err, e.err); end
        end
    endtask

    task automatic test_sp();
        step_t s[7];
        exp_t  e;
        s[0] = '{0,1,0, 1,14,2,'h00001000, 0,0,0,0, 0,0,   0,0,0,0};
        s[1] = '{0,1,1, 1,14,2,'h00002000, 0,0,0,0, 0,0,   0,0,0,0};
        s[2] = '{0,1,0, 0,0,0,0,           0,0,0,0, 14,14, 'h1000,'h1000,0,0};
        s[3] = '{0,1,1, 0,0,0,0,           0,0,0,0, 14,14, 'h2000,'h2000,0,0};
        s[4] = '{0,1,1, 1,14,1,'h00008000, 0,0,0,0, 0,0,   0,0,0,0};
        s[5] = '{0,1,0, 0,0,0,0,           0,0,0,0, 14,14, 'h1000,'h1000,0,0};
        s[6] = '{0,1,1, 0,0,0,0,           0,0,0,0, 14,0,  'hFFFF8000,0,0,0};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(s[i], $sformatf("sp%0d", i));
            @(posedge MCLK); #1;
            e = sb.pop_front();
            checks++; if (bus.ra_data !== e.ra) begin errors++; $display("[TB] FAIL %s ra_data got %h want %h", e.tag, bus.ra_data, e.ra); end
            checks++; if (bus.rb_data !== e.rb) begin errors++; $display("[TB] FAIL %s rb_data got %h want %h", e.tag, bus.rb_data, e.rb); end
            checks++; if (bus.collision !== e.coll) begin errors++; $display("[TB] FAIL %s collision got %b want %b", e.tag, bus.collision, e.coll); end
            checks++; if (bus.size_err !== e.err) begin errors++; $display("[TB] FAIL %s size_err got %b want %b", e.tag, bus.size_err, e.err); end
        end
    endtask

    task automatic test_collision();
        step_t s[8];
        exp_t  e;
        s[0] = '{0,1,0, 1,1,2,'h11111111,  1,1,2,'h22222222,  0,0,  0,0,1,0};
        s[1] = '{0,1,0, 0,0,0,0,           0,0,0,0,           1,1,  'h11111111,'h11111111,0,0};
        s[2] = '{0,1,0, 1,2,0,'h000000AA,  1,2,2,'h22222222,  0,0,  0,0,1,0};
        s[3] = '{0,1,0, 0,0,0,0,           0,0,0,0,           2,2,  'h000000AA,'h000000AA,0,0};
        s[4] = '{0,1,0, 1,4,2,'h44444444,  1,6,2,'h66666666,  0,0,  0,0,0,0};
        s[5] = '{0,1,0, 0,0,0,0,           0,0,0,0,           4,6,  'h44444444,'h66666666,0,0};
        s[6] = '{0,1,0, 1,14,2,'h0BAD0000, 1,14,2,'h0BAD1111, 0,0,  0,0,1,0};
        s[7] = '{0,1,0, 0,0,0,0,           0,0,0,0,           14,0, 'h0BAD0000,0,0,0};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(s[i], $sformatf("coll%0d", i));
            @(posedge MCLK); #1;
            e = sb.pop_front();
            checks++; if (bus.ra_data !== e.ra) begin errors++; $display("[TB] FAIL %s ra_data got %h want %h", e.tag, bus.ra_data, e.ra); end
            checks++; if (bus.rb_data !== e.rb) begin errors++; $display("[TB] FAIL %s rb_data got %h want %h", e.tag, bus.rb_data, e.rb); end
            checks++; if (bus.collision !== e.coll) begin errors++; $display("[TB] FAIL %s collision got %b want %b", e.tag, bus.collision, e.coll); end
            checks++; if (bus.size_err !== e.err) begin errors++; $display("[TB] FAIL %s size_err got %b want %b", e.tag, bus.size_err, e.err); end
        end
    endtask

    task automatic test_back_to_back();
        step_t       s[6];
        exp_t        e;
        logic [31:0] v;
        v = BYP ? 32'h55 : 32'h77;
        s[0] = '{0,1,0, 1,5,2,'h77, 0,0,0,0,    0,0, 0,0,0,0};
        s[1] = '{0,1,0, 1,5,2,'h55, 0,0,0,0,    5,5, v,v,0,0};
        s[2] = '{0,0,0, 1,5,2,'hAA, 1,5,2,'hBB, 3,3, v,v,0,0};
        s[3] = '{0,1,0, 0,0,0,0,    0,0,0,0,    5,3, 'h55,'h1234CDEF,0,0};
        s[4] = '{1,0,0, 0,0,0,0,    0,0,0,0,    5,5, 0,0,0,0};
        s[5] = '{0,1,0, 0,0,0,0,    0,0,0,0,    5,3, 0,0,0,0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(s[i], $sformatf("b2b%0d", i));
            @(posedge MCLK); #1;
            e = sb.pop_front();
            checks++; if (bus.ra_data !== e.ra) begin errors++; $display("[TB] FAIL %s ra_data got %h want %h", e.tag, bus.ra_data, e.ra); end
            checks++; if (bus.rb_data !== e.rb) begin errors++; $display("[TB] FAIL %s rb_data got %h want %h", e.tag, bus.rb_data, e.rb); end
            checks++; if (bus.collision !== e.coll) begin errors++; $display("[TB] FAIL %s collision got %b want %b", e.tag, bus.collision, e.coll); end
            checks++; if (bus.size_err !== e.err) begin errors++; $display("[TB] FAIL %s size_err got %b want %b", e.tag, bus.size_err, e.err); end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.ce         = 1'b0;
        bus.super_mode = 1'b0;
        bus.wa_en      = 1'b0;
        bus.wa_sel     = '0;
        bus.wa_size    = '0;
        bus.wa_data    = '0;
        bus.wb_en      = 1'b0;
        bus.wb_sel     = '0;
        bus.wb_size    = '0;
        bus.wb_data    = '0;
        bus.ra_sel     = '0;
        bus.rb_sel     = '0;
        @(posedge MCLK); #1;
        test_reset();
        test_dsize();
        test_areg();
        test_sp();
        test_collision();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/m68k_regfile_gen.md
Name: m68k_regfile_gen

Overview:
- Parametrised successor to the 68k core's hard-wired data/address register write-strobe decode.
- Holds a configurable bank of data and address registers behind two write ports and two registered read ports.
- Implements 68k size semantics, A-register sign extension, USP/SSP banking of the top address register, and write-port collision arbitration.
- Sits between the microcode decode and the ALU/address datapath; advances only on the core phase enable.

Parameters:
NDATA, 8, number of data registers D0..D(NDATA-1)
NADDR, 8, number of address registers; the highest one is the banked stack pointer
DW, 32, register width; legal values are 16..64 in multiples of 8
SELW, 4, register select width; must satisfy 2**SELW >= NDATA+NADDR

Ports:
MCLK  in  1  system clock; all state changes on posedge
reset  in  1  synchronous, active-high; overrides ce
ce  in  1  phase enable; no state changes when 0 (reset excepted)
super  in  1  supervisor mode; selects SSP (1) or USP (0) for the stack-pointer select
wa_en  in  1  write port A enable
wa_sel  in  SELW  port A register select; 0..NDATA-1 = D regs, NDATA..NDATA+NADDR-1 = A regs
wa_size  in  2  00 byte, 01 word, 1x long
wa_data  in  DW  port A write data
wb_en, wb_sel, wb_size, wb_data  in  1/SELW/2/DW  write port B, same encoding as port A
ra_sel  in  SELW  read port A select
rb_sel  in  SELW  read port B select
ra_data  out  DW  registered read data, port A
rb_data  out  DW  registered read data, port B
collision  out  1  one-cycle pulse: both ports wrote the same physical register
size_err  out  1  one-cycle pulse: illegal byte write to an A register, or select out of range

Behaviour:
- Storage holds NDATA+NADDR+1 registers: the extra one is the second stack pointer. Physical SP = SSP if super=1, else USP, sampled in the same cycle as the access.
- Reset: all registers, ra_data, rb_data, collision and size_err are cleared to 0 on the next edge, regardless of ce. A write presented in the reset cycle is discarded.
- ce=0: registers and read outputs hold; collision and size_err are forced to 0.
- D-register writes, ce=1:
  - byte writes [7:0]; word writes [15:0]; long writes [DW-1:0].
  - Untouched bits keep their value.
- A-register writes:
  - word write: the data is sign-extended from bit 15 to DW.
  - long write: full width.
  - byte write: ignored, and size_err pulses.
- Select >= NDATA+NADDR, on a write or a read: the write is ignored and size_err pulses. For a read, the data output gets 0.
- Collision: both ports enabled and targeting the same physical register (after SP banking) with ce=1.
  - Port A is written; port B is suppressed entirely, with no byte merge; collision=1 for that cycle.
  - Different physical registers (for example USP vs SSP is never a collision) are both written.
- Reads: on a ce=1 edge, ra_data/rb_data load the selected register. Latency is 1 ce-cycle.
  - Without bypass, the value loaded is the pre-write value.
  - Both read ports may select the same register.
- Changing super only changes SP mapping; it never copies USP to or from SSP.
- All arithmetic is width-exact. No carry or overflow: sign extension is the only width transformation.

Optional Feature:
M68K_REGFILE_BYPASS_EN:
- Defined: a read whose physical register is written in the same ce cycle loads the post-write value, including size merge, sign extension and the collision winner.
- Undefined: reads load the pre-write value; new data is visible one ce-cycle later.

Test Plan:
1. Reset then ce=1, ra_sel=0 -> ra_data=0, collision=0, size_err=0.
2. D3=0x12345678; byte write 0xAB to D3; next cycle read D3 -> 0x123456AB. Word write 0xCDEF -> 0x1234CDEF.
3. Word write 0x8001 to A2 (sel=NDATA+2); read -> 0xFFFF8001. Byte write to A2 -> size_err=1, A2 unchanged.
4. super=0, long write 0x1000 to SP sel; super=1, long write 0x2000 to SP sel; read SP with super=0 -> 0x1000, with super=1 -> 0x2000, collision=0 throughout.
5. Same cycle, A writes D1=0x11111111 long and B writes D1=0x22222222 long -> collision=1 for one cycle, D1=0x11111111.
6. Write D5=0x55 and read D5 in the same ce cycle -> ra_data=old D5 (bypass off) or 0x55 (bypass on). Toggle ce=0 mid-sequence -> outputs hold. Reset asserted with ce=0 -> all cleared.
